mem_arbiter_ctrl: RTL and testbench

//  Memory-side responder for the cache request/wait protocol. Arbitrates icache fetches and dcache

---
 rtl/mem_arbiter_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl.sv
// rtl/mem_arbiter_ctrl.sv - icache/dcache request/wait arbiter onto one single-port RAM
//
// Purpose:
//   Grants one cache at a time onto a single-port RAM. The dcache has priority,
//   and a dcache grant is locked across both beats of a two-word block. The
//   access completes when ram_ready pulses. If an access waits too long for
//   ram_ready, the controller parks in a sticky error state.
//
// Ports:
//   CLK, RST             clock (rising edge); asynchronous active-high reset
//   iREN, iaddr          icache read request and address
//   iload, iwait         icache read data and wait (low only in the completing cycle)
//   dREN, dWEN           dcache read/write request (both high means write)
//   daddr, dstore        dcache address and write data
//   dload, dwait         dcache read data and wait (low only in the completing cycle)
//   ram_ren, ram_wen     RAM read/write strobes (mutually exclusive)
//   ram_addr, ram_store  RAM address (from the granted port) and write data
//   ram_load, ram_ready  RAM read data and one-cycle completion pulse
//   mem_err              sticky timeout flag, cleared only by RST
module mem_arbiter_ctrl #(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dwait,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_store,
  input  logic [WORD_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              mem_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DSRV  = 3'd1;
  localparam logic [2:0] ISRV  = 3'd2;
  localparam logic [2:0] DHOLD = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state, next_state;
  logic          beat, next_beat;
  logic [TW-1:0] tmo, next_tmo;
  logic          dreq;

  assign dreq = dREN | dWEN;

  // Next-state logic. A request that drops takes priority over a ram_ready
  // in the same cycle, so a withdrawn access never reports completion.
  always_comb begin
    next_state = state;
    next_beat  = beat;
    next_tmo   = tmo;
    case (state)
      IDLE: begin
        next_tmo = '0;
        if (dreq)      next_state = DSRV;
        else if (iREN) next_state = ISRV;
      end
      DSRV: begin
        if (!dreq) begin
          next_state = IDLE;
          next_beat  = 1'b0;
          next_tmo   = '0;
        end else if (ram_ready) begin
          next_tmo = '0;
          if (!beat) begin
            // First beat done: hold the lock for one cycle so the second beat can follow.
            next_state = DHOLD;
            next_beat  = 1'b1;
          end else begin
            next_state = IDLE;
            next_beat  = 1'b0;
          end
        end else if (tmo == TMO_LAST) begin
          next_state = ERR;
          next_tmo   = '0;
        end else begin
          next_tmo = tmo + 1'b1;
        end
      end
      ISRV: begin
        if (!iREN) begin
          next_state = IDLE;
          next_beat  = 1'b0;
          next_tmo   = '0;
        end else if (ram_ready) begin
          next_state = IDLE;
          next_tmo   = '0;
        end else if (tmo == TMO_LAST) begin
          next_state = ERR;
          next_tmo   = '0;
        end else begin
          next_tmo = tmo + 1'b1;
        end
      end
      DHOLD: begin
        next_tmo = '0;
        if (dreq) begin
          next_state = DSRV;
        end else begin
          // No second beat arrived (single-word store), so release the lock.
          next_state = IDLE;
          next_beat  = 1'b0;
        end
      end
      ERR: begin
        next_state = ERR;
        next_tmo   = '0;
      end
      default: begin
        next_state = IDLE;
        next_beat  = 1'b0;
        next_tmo   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      beat  <= 1'b0;
      tmo   <= '0;
    end else begin
      state <= next_state;
      beat  <= next_beat;
      tmo   <= next_tmo;
    end
  end

  // The strobes depend only on state and the request lines. ram_ready
  // affects only the wait flags and the load data.
  always_comb begin
    ram_ren  = 1'b0;
    ram_wen  = 1'b0;
    ram_addr = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      DSRV: begin
        ram_addr = daddr;
        ram_wen  = dWEN;
        ram_ren  = dREN & ~dWEN;
        if (dreq && ram_ready) begin
          dwait = 1'b0;
          if (!dWEN) dload = ram_load;
        end
      end
      ISRV: begin
        ram_addr = iaddr;
        ram_ren  = iREN;
        if (iREN && ram_ready) begin
          iwait = 1'b0;
          iload = ram_load;
        end
      end
      default: begin
      end
    endcase
  end

  assign ram_store = dstore;
  assign mem_err   = (state == ERR);

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb/tb_mem_arbiter_ctrl.sv - directed and randomized scoreboard bench for mem_arbiter_ctrl
module tb_mem_arbiter_ctrl;

  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        mem_err;

  mem_arbiter_ctrl #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  bit rand_on = 1'b0;
  bit auto_ram = 1'b0;
  bit in_pair = 1'b0;

  logic        dir_ready = 1'b0;
  logic [31:0] dir_load = '0;
  logic        env_ready = 1'b0;
  logic [31:0] env_load = '0;
  assign ram_ready = auto_ram ? env_ready : dir_ready;
  assign ram_load  = auto_ram ? env_load  : dir_load;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bus();
    return {28'd0, ram_ren, ram_wen, iwait, dwait};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rdy(input logic r, input logic [31:0] d);
    dir_ready = r;
    dir_load  = d;
  endtask

  task automatic wait_done(input bit is_d, output bit done);
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge CLK);
      done = is_d ? !dwait : !iwait;
    end
  endtask

  // RAM model: random 0..2 cycle latency, backed by an associative memory.
  initial begin : ram_env
    int lat;
    lat = -1;
    forever begin
      @(posedge CLK);
      #2;
      if (auto_ram) begin
        if (ram_ren || ram_wen) begin
          if (lat < 0) lat = $urandom_range(0, 2);
          if (lat == 0) begin
            env_ready = 1'b1;
            if (ram_wen) begin
              env_mem[ram_addr] = ram_store;
              env_load = $urandom;
            end else begin
              env_load = env_mem.exists(ram_addr) ? env_mem[ram_addr] : init_word(ram_addr);
            end
            lat = -1;
          end else begin
            env_ready = 1'b0;
            lat--;
          end
        end else begin
          env_ready = 1'b0;
          lat = -1;
        end
      end
    end
  end

  exp_t mi;
  exp_t md;
  always @(negedge CLK) begin
    if (rand_on) begin
      chk("excl_strobe", 32'(ram_ren & ram_wen), 32'd0);
      if (in_pair && (ram_ren || ram_wen))
        chk("pair_lock", 32'(ram_addr >= 32'h100), 32'd1);
      if (!iwait) begin
        if (iq.size() == 0) chk("i_unexpected", 32'(iwait), 32'd1);
        else begin
          mi = iq.pop_front();
          chk("i_addr", ram_addr, mi.addr);
          chk("i_data", iload, mi.data);
        end
      end
      if (!dwait) begin
        if (dq.size() == 0) chk("d_unexpected", 32'(dwait), 32'd1);
        else begin
          md = dq.pop_front();
          chk("d_addr", ram_addr, md.addr);
          chk("d_wen", 32'(ram_wen), 32'(md.wr));
          if (md.wr) begin
            chk("d_store", ram_store, md.data);
            chk("d_load_wr", dload, 32'd0);
          end else begin
            chk("d_load", dload, md.data);
          end
        end
      end
    end
  end

  task automatic icache_drv();
    exp_t e;
    bit done;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 4)) step();
      e.addr = 32'($urandom_range(0, 63)) << 2;
      e.wr   = 1'b0;
      e.data = init_word(e.addr);
      iaddr = e.addr;
      iREN  = 1'b1;
      iq.push_back(e);
      wait_done(1'b0, done);
      chk("i_progress", 32'(done), 32'd1);
      step();
      iREN = 1'b0;
      if (!done) return;
    end
  endtask

  task automatic dcache_drv();
    exp_t e;
    bit done;
    int nb;
    logic [31:0] base;
    for (int n = 0; n < 70; n++) begin
      repeat ($urandom_range(1, 3)) step();
      nb   = $urandom_range(1, 2);
      base = 32'h100 + (32'($urandom_range(0, 31)) << 3);
      for (int b = 0; b < nb; b++) begin
        e.addr = base + 32'(b * 4);
        e.wr   = 1'($urandom_range(0, 1));
        dstore = $urandom;
        daddr  = e.addr;
        if (e.wr) begin
          e.data = dstore;
          ref_mem[e.addr] = dstore;
          dWEN = 1'b1;
          dREN = 1'($urandom_range(0, 1));
        end else begin
          e.data = ref_rd(e.addr);
          dWEN = 1'b0;
          dREN = 1'b1;
        end
        dq.push_back(e);
        if (b == 1) begin
          in_pair = 1'b1;
          @(negedge CLK);
          chk("dhold_bubble", 32'({ram_ren, ram_wen, dwait}), 32'd1);
        end
        wait_done(1'b1, done);
        chk("d_progress", 32'(done), 32'd1);
        step();
        in_pair = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        if (!done) return;
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    iREN = 1'b0; iaddr = '0;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    #3;
    chk("rst_bus", bus(), 32'b0011);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    step(); step();
    RST = 1'b0;

    // 1: icache read, ready on the third serve cycle
    iREN = 1'b1; iaddr = 32'h40;
    @(negedge CLK); chk("t1_c0", bus(), 32'b0011);
    step(); @(negedge CLK); chk("t1_c1", bus(), 32'b1011); chk("t1_addr", ram_addr, 32'h40);
    step(); @(negedge CLK); chk("t1_c2", bus(), 32'b1011);
    step(); rdy(1'b1, 32'hDEADBEEF);
    @(negedge CLK); chk("t1_done", bus(), 32'b1001); chk("t1_iload", iload, 32'hDEADBEEF);
    step(); rdy(1'b0, 32'h0); iREN = 1'b0;
    @(negedge CLK); chk("t1_idle", bus(), 32'b0011);

    // 2: dcache two-beat read beats icache
    step(); dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h40;
    @(negedge CLK); chk("t2_c0", bus(), 32'b0011);
    step(); rdy(1'b1, 32'h1111_0001);
    @(negedge CLK); chk("t2_b0", bus(), 32'b1010); chk("t2_a0", ram_addr, 32'h100);
    chk("t2_d0", dload, 32'h1111_0001);
    step(); rdy(1'b0, 32'h0); daddr = 32'h104;
    @(negedge CLK); chk("t2_hold", bus(), 32'b0011);
    step(); rdy(1'b1, 32'h1111_0002);
    @(negedge CLK); chk("t2_b1", bus(), 32'b1010); chk("t2_a1", ram_addr, 32'h104);
    chk("t2_d1", dload, 32'h1111_0002);
    step(); rdy(1'b0, 32'h0); dREN = 1'b0;
    @(negedge CLK); chk("t2_idle", bus(), 32'b0011);
    step(); rdy(1'b1, 32'h2222_0003);
    @(negedge CLK); chk("t2_i", bus(), 32'b1001); chk("t2_ia", ram_addr, 32'h40);
    chk("t2_id", iload, 32'h2222_0003);
    step(); rdy(1'b0, 32'h0); iREN = 1'b0;

    // 3: single-word dcache store, then icache
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678; iREN = 1'b1; iaddr = 32'h40;
    @(negedge CLK); chk("t3_c0", bus(), 32'b0011);
    step(); rdy(1'b1, 32'hFFFF_FFFF);
    @(negedge CLK); chk("t3_wr", bus(), 32'b0110); chk("t3_store", ram_store, 32'h12345678);
    chk("t3_addr", ram_addr, 32'h200); chk("t3_dload", dload, 32'd0);
    step(); rdy(1'b0, 32'h0); dWEN = 1'b0;
    @(negedge CLK); chk("t3_hold", bus(), 32'b0011);
    step(); @(negedge CLK); chk("t3_idle", bus(), 32'b0011);
    step(); rdy(1'b1, 32'h3333_0004);
    @(negedge CLK); chk("t3_i", bus(), 32'b1001); chk("t3_id", iload, 32'h3333_0004);
    step(); rdy(1'b0, 32'h0); iREN = 1'b0;

    // 4: timeout to sticky error, cleared by reset
    iREN = 1'b1; iaddr = 32'h40;
    @(negedge CLK); chk("t4_c0", bus(), 32'b0011);
    for (int k = 1; k <= TIMEOUT; k++) begin
      step(); @(negedge CLK);
      chk("t4_wait", bus(), 32'b1011); chk("t4_noerr", 32'(mem_err), 32'd0);
    end
    step(); @(negedge CLK); chk("t4_err_bus", bus(), 32'b0011); chk("t4_err", 32'(mem_err), 32'd1);
    step(); dREN = 1'b1; rdy(1'b1, 32'h5);
    @(negedge CLK); chk("t4_sticky_bus", bus(), 32'b0011); chk("t4_sticky", 32'(mem_err), 32'd1);
    step(); rdy(1'b0, 32'h0); dREN = 1'b0; iREN = 1'b0;
    #2 RST = 1'b1;
    #1 chk("t4_clr", 32'(mem_err), 32'd0);
    step(); RST = 1'b0;

    // 5: reset during the second beat of a dcache store
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'hA5A5A5A5;
    @(negedge CLK); chk("t5_c0", bus(), 32'b0011);
    step(); rdy(1'b1, 32'h0);
    @(negedge CLK); chk("t5_b0", bus(), 32'b0110);
    step(); rdy(1'b0, 32'h0); daddr = 32'h304;
    @(negedge CLK); chk("t5_hold", bus(), 32'b0011);
    step(); @(negedge CLK); chk("t5_wen", bus(), 32'b0111);
    #1 RST = 1'b1;
    #1 chk("t5_rst_bus", bus(), 32'b0011);
    step(); RST = 1'b0; daddr = 32'h308; iREN = 1'b1; iaddr = 32'h40;
    @(negedge CLK); chk("t5_r0", bus(), 32'b0011);
    step(); rdy(1'b1, 32'h0);
    @(negedge CLK); chk("t5_rb0", bus(), 32'b0110);
    step(); rdy(1'b0, 32'h0); dWEN = 1'b0;
    @(negedge CLK); chk("t5_rhold", bus(), 32'b0011);
    step(); @(negedge CLK); chk("t5_ridle", bus(), 32'b0011);
    step(); rdy(1'b1, 32'h4444_0005);
    @(negedge CLK); chk("t5_i", bus(), 32'b1001);
    step(); rdy(1'b0, 32'h0); iREN = 1'b0;

    // 6: dcache withdrawal, stray ready ignored
    dREN = 1'b1; daddr = 32'h400;
    @(negedge CLK); chk("t6_c0", bus(), 32'b0011);
    step(); @(negedge CLK); chk("t6_srv", bus(), 32'b1011);
    step(); dREN = 1'b0;
    @(negedge CLK); chk("t6_drop", bus(), 32'b0011);
    step(); rdy(1'b1, 32'h77);
    @(negedge CLK); chk("t6_stray", bus(), 32'b0011); chk("t6_err", 32'(mem_err), 32'd0);
    step(); rdy(1'b0, 32'h0); iREN = 1'b1; iaddr = 32'h40;
    @(negedge CLK); chk("t6_idle", bus(), 32'b0011);
    step(); rdy(1'b1, 32'h6666_0006);
    @(negedge CLK); chk("t6_i", bus(), 32'b1001); chk("t6_id", iload, 32'h6666_0006);
    step(); rdy(1'b0, 32'h0); iREN = 1'b0;

    // Randomized traffic against the scoreboard
    step();
    auto_ram = 1'b1;
    rand_on  = 1'b1;
    fork
      icache_drv();
      dcache_drv();
    join
    repeat (5) step();
    rand_on = 1'b0;
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("end_err", 32'(mem_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
